// File: rtl/vlc_pkg.sv
// Shared constants and FSM state encoding for the VLC bit packer.
package vlc_pkg;

    localparam int WORD_W = 32;
    localparam int ACC_W  = 2 * WORD_W;
    localparam int FILL_W = 6;
    localparam int LEN_W  = 6;

    typedef logic [0:0] vlc_state_t;
    localparam vlc_state_t RUN   = 1'b0;
    localparam vlc_state_t FLUSH = 1'b1;

endpackage

// File: rtl/vlc_bit_insert.sv
// Masks a right-aligned codeword to its length and ORs it into the
// left-aligned accumulator directly below the currently valid bits.
module vlc_bit_insert
    import vlc_pkg::*;
(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [FILL_W-1:0] i_fill,
    input  logic [WORD_W-1:0] i_codeword,
    input  logic [LEN_W-1:0]  i_code_len,
    output logic [ACC_W-1:0]  o_acc
);

    logic [ACC_W-1:0] w_mask;
    logic [ACC_W-1:0] w_code;
    logic [6:0]       w_shift;

    assign w_mask  = (ACC_W'(1) << i_code_len) - ACC_W'(1);
    assign w_code  = {{WORD_W{1'b0}}, i_codeword} & w_mask;
    // A zero-length code gives a shift of 64 here, which is harmless: w_code is 0.
    assign w_shift = 7'(ACC_W) - 7'(i_fill) - 7'(i_code_len);
    assign o_acc   = i_acc | (w_code << w_shift);

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs (codeword, length) pairs into an MSB-first stream of 32-bit words
// and reports the per-slice bit count when a slice is flushed.
module vlc_bit_packer
    import vlc_pkg::*;
#(
    parameter int WORD_W_P = WORD_W,
    parameter int ACC_W_P  = ACC_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] codeword,
    input  logic [31:0] code_len,
    input  logic        flush,
    output logic [31:0] out_word,
    output logic        out_valid,
    output logic        out_last,
    output logic        flush_done,
    output logic [31:0] slice_bits,
    output logic        len_err
);

    vlc_state_t        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [FILL_W-1:0] r_fill;
    logic [31:0]       r_bit_cnt;
    logic [31:0]       r_out_word;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_flush_done;
    logic [31:0]       r_slice_bits;
    logic              r_len_err;

    logic              w_len_bad;
    logic [LEN_W-1:0]  w_ins_len;
    logic [ACC_W-1:0]  w_acc_ins;
    logic [6:0]        w_fill_sum;
    logic              w_emit;
    logic [FILL_W-1:0] w_fill_rem;
    logic [ACC_W-1:0]  w_acc_rem;

    // Out-of-range lengths are inserted as zero bits so the state stays untouched.
    assign w_len_bad = (code_len > 32'd32);
    assign w_ins_len = w_len_bad ? '0 : code_len[LEN_W-1:0];

    vlc_bit_insert u_insert (
        .i_acc      (r_acc),
        .i_fill     (r_fill),
        .i_codeword (codeword),
        .i_code_len (w_ins_len),
        .o_acc      (w_acc_ins)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_fill_sum = 7'(r_fill) + 7'(w_ins_len);
        w_emit     = (w_fill_sum >= 7'd32);
        w_fill_rem = w_fill_sum[FILL_W-1:0];
        w_acc_rem  = w_acc_ins;
        if (w_emit) begin
            w_fill_rem = FILL_W'(w_fill_sum - 7'd32);
            w_acc_rem  = {w_acc_ins[WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_acc        <= '0;
            r_fill       <= '0;
            r_bit_cnt    <= '0;
            r_out_word   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_flush_done <= 1'b0;
            r_slice_bits <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            r_slice_bits <= '0;
            case (r_state)
                RUN: begin
                    r_acc       <= w_acc_rem;
                    r_fill      <= w_fill_rem;
                    r_bit_cnt   <= r_bit_cnt + 32'(w_ins_len);
                    r_out_valid <= w_emit;
                    r_out_word  <= w_emit ? w_acc_ins[ACC_W-1 -: WORD_W] : '0;
                    // A flush-cycle word that leaves nothing behind is the slice's last word.
                    r_out_last  <= flush && w_emit && (w_fill_rem == '0);
                    if (w_len_bad) begin
                        r_len_err <= 1'b1;
                    end
                    if (flush) begin
                        r_state <= FLUSH;
                    end
                end
                default: begin
                    r_out_valid  <= (r_fill != '0);
                    r_out_last   <= (r_fill != '0);
                    r_out_word   <= (r_fill != '0) ? r_acc[ACC_W-1 -: WORD_W] : '0;
                    r_flush_done <= 1'b1;
                    r_slice_bits <= r_bit_cnt;
                    r_acc        <= '0;
                    r_fill       <= '0;
                    r_bit_cnt    <= '0;
                    if (code_len != 32'd0) begin
                        r_len_err <= 1'b1;
                    end
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign out_word   = r_out_word;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign flush_done = r_flush_done;
    assign slice_bits = r_slice_bits;
    assign len_err    = r_len_err;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed-vector bench for vlc_bit_packer with hand-computed expectations.
module tb_vlc_bit_packer;

    logic        clk;
    logic        reset;
    logic [31:0] codeword;
    logic [31:0] code_len;
    logic        flush;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_last;
    logic        flush_done;
    logic [31:0] slice_bits;
    logic        len_err;

    int n_cmp = 0;
    int n_err = 0;

    vlc_bit_packer dut (
        .clk        (clk),
        .reset      (reset),
        .codeword   (codeword),
        .code_len   (code_len),
        .flush      (flush),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .flush_done (flush_done),
        .slice_bits (slice_bits),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Applies one input cycle; afterwards the outputs show that cycle's result.
    task automatic drive(input logic [31:0] cw, input logic [31:0] len, input logic fl);
        codeword = cw;
        code_len = len;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        codeword = '0;
        code_len = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_word",  out_word, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done",  32'(flush_done), 32'd0);
        reset = 1'b0;

        // Idle with code_len = 0
        for (int i = 0; i < 3; i++) begin
            drive(32'h0, 32'd0, 1'b0);
            check("idle_word",  out_word, 32'h0);
            check("idle_flags", {28'd0, out_valid, out_last, flush_done, len_err}, 32'h0);
        end

        // Eight nibbles 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(32'(i), 32'd4, 1'b0);
            if (i < 8) check("nib_valid", 32'(out_valid), 32'd0);
        end
        check("nib_word",  out_word, 32'h12345678);
        check("nib_valid", 32'(out_valid), 32'd1);

        // 18 + 14 bits
        drive(32'h0003_FFFF, 32'd18, 1'b0);
        check("l18_valid", 32'(out_valid), 32'd0);
        drive(32'h0000_2AAA, 32'd14, 1'b0);
        check("l14_word",  out_word, 32'hFFFF_EAAA);
        check("l14_valid", 32'(out_valid), 32'd1);

        // Flush with fill = 0 and no flush-cycle word: done pulse only
        drive(32'h0, 32'd0, 1'b1);
        check("f0_n1_valid", 32'(out_valid), 32'd0);
        check("f0_n1_done",  32'(flush_done), 32'd0);
        drive(32'h0, 32'd0, 1'b0);
        check("f0_n2_done",  32'(flush_done), 32'd1);
        check("f0_n2_valid", 32'(out_valid), 32'd0);
        check("f0_n2_last",  32'(out_last), 32'd0);
        check("f0_n2_bits",  slice_bits, 32'd64);

        // Seven 0xF nibbles, then 0xA5 (8 bits), then flush
        for (int i = 0; i < 7; i++) drive(32'hFFFF_FFFF, 32'd4, 1'b0);
        drive(32'h0000_00A5, 32'd8, 1'b0);
        check("t4_word",  out_word, 32'hFFFF_FFFA);
        check("t4_last",  32'(out_last), 32'd0);
        drive(32'h0, 32'd0, 1'b1);
        check("t4_n1_valid", 32'(out_valid), 32'd0);
        drive(32'h0, 32'd0, 1'b0);
        check("t4_n2_word",  out_word, 32'h5000_0000);
        check("t4_n2_flags", {29'd0, out_valid, out_last, flush_done}, 32'h7);
        check("t4_n2_bits",  slice_bits, 32'd36);
        drive(32'h0, 32'd0, 1'b0);
        check("t4_n3_flags", {29'd0, out_valid, out_last, flush_done}, 32'h0);

        // Flush cycle completes a word with bits left over
        drive(32'h0, 32'd30, 1'b0);
        check("t5_valid0", 32'(out_valid), 32'd0);
        drive(32'hFFFF_FFFF, 32'd4, 1'b1);
        check("t5_n1_word",  out_word, 32'h0000_0003);
        check("t5_n1_flags", {29'd0, out_valid, out_last, flush_done}, 32'h4);
        drive(32'h0, 32'd0, 1'b0);
        check("t5_n2_word",  out_word, 32'hC000_0000);
        check("t5_n2_flags", {29'd0, out_valid, out_last, flush_done}, 32'h7);
        check("t5_n2_bits",  slice_bits, 32'd34);

        // Flush cycle completes a word exactly: that word carries out_last
        drive(32'hCAFE_F00D, 32'd32, 1'b1);
        check("t5b_n1_word",  out_word, 32'hCAFE_F00D);
        check("t5b_n1_flags", {29'd0, out_valid, out_last, flush_done}, 32'h6);
        drive(32'h0, 32'd0, 1'b0);
        check("t5b_n2_flags", {29'd0, out_valid, out_last, flush_done}, 32'h1);
        check("t5b_n2_bits",  slice_bits, 32'd32);

        // Empty slice
        drive(32'h0, 32'd0, 1'b1);
        drive(32'h0, 32'd0, 1'b0);
        check("empty_flags", {29'd0, out_valid, out_last, flush_done}, 32'h1);
        check("empty_bits",  slice_bits, 32'd0);
        check("empty_err",   32'(len_err), 32'd0);

        // Over-length code is dropped and sets the sticky error
        drive(32'h1234_5678, 32'd33, 1'b0);
        check("t6_err",   32'(len_err), 32'd1);
        check("t6_valid", 32'(out_valid), 32'd0);
        drive(32'hDEAD_BEEF, 32'd32, 1'b0);
        check("t6_word",  out_word, 32'hDEAD_BEEF);
        check("t6_valid", 32'(out_valid), 32'd1);
        drive(32'h0, 32'd0, 1'b0);
        check("t6_sticky", 32'(len_err), 32'd1);

        // Reset mid-slice discards partial bits and clears the error
        drive(32'h7, 32'd3, 1'b0);
        reset = 1'b1;
        drive(32'h0, 32'd0, 1'b0);
        check("mrst_err",   32'(len_err), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_word",  out_word, 32'h0);
        reset = 1'b0;
        drive(32'h0, 32'd0, 1'b1);
        check("mrst_n1_valid", 32'(out_valid), 32'd0);
        drive(32'h0, 32'd0, 1'b0);
        check("mrst_n2_flags", {29'd0, out_valid, out_last, flush_done}, 32'h1);
        check("mrst_n2_bits",  slice_bits, 32'd0);

        // A codeword arriving during FLUSH is dropped and flagged
        drive(32'h0, 32'd0, 1'b1);
        drive(32'h1F, 32'd5, 1'b0);
        check("fl_in_err",  32'(len_err), 32'd1);
        check("fl_in_done", 32'(flush_done), 32'd1);
        drive(32'h0, 32'd0, 1'b1);
        drive(32'h0, 32'd0, 1'b0);
        check("fl_in_bits",  slice_bits, 32'd0);
        check("fl_in_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
